// File: rtl/mux_nto1_scan.sv
// Registered N-channel, WIDTH-bit multiplexer with a valid/ready output.
// Manual mode loads the channel on sel. Scan mode walks the enabled channels
// round-robin and can insert idle cycles between transfers.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | no sample held; load as soon as a source is available
// ST_HOLD | y/y_ch hold a sample waiting for y_ready
// ST_GAP  | scan-mode idle cycles after an accepted transfer
module mux_nto1_scan #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 8,
  parameter int GAP    = 0,
  localparam int SEL_W = $clog2(NUM_CH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH*WIDTH-1:0]   din,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  input  logic [NUM_CH-1:0]         ch_en,
  output logic [WIDTH-1:0]          y,
  output logic [SEL_W-1:0]          y_ch,
  output logic                      y_valid,
  input  logic                      y_ready,
  output logic                      scan_wrap
);

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_GAP} state_t;

  // GAP cycles are counted down to zero; the counter starts at GAP-1 so the
  // load happens on the edge that ends the last idle cycle.
  localparam logic [7:0] GAP_LD = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [7:0]       gap_cnt;
  logic [SEL_W-1:0] last_ch;
  logic             have_last;

  logic             scan_found;
  logic [SEL_W-1:0] scan_ch;
  logic             man_ok;
  logic             src_ok;
  logic [SEL_W-1:0] load_ch;
  logic             accept;
  logic             gap_mode;
  logic             load_slot;
  logic             do_load;

  // First enabled channel at or above the scan pointer, searching upward with
  // wrap. Iterating from the far end down leaves the nearest match standing.
  always_comb begin
    scan_found = 1'b0;
    scan_ch    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      int j;
      j = int'(ptr) + i;
      if (j >= NUM_CH) j = j - NUM_CH;
      if (ch_en[j]) begin
        scan_found = 1'b1;
        scan_ch    = SEL_W'(j);
      end
    end
  end

  // Source selection and the decision whether this edge loads a new sample.
  always_comb begin
    man_ok   = int'(sel) < NUM_CH;
    src_ok   = mode ? scan_found : man_ok;
    load_ch  = mode ? scan_ch : sel;
    accept   = y_valid && y_ready;
    gap_mode = mode && (GAP > 0);
    unique case (state)
      ST_IDLE: load_slot = 1'b1;
      ST_HOLD: load_slot = accept && !gap_mode;
      ST_GAP:  load_slot = (gap_cnt == 8'd0);
      default: load_slot = 1'b0;
    endcase
    do_load = load_slot && src_ok;
  end

  // Control FSM with registered data, handshake and wrap-pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      y         <= '0;
      y_ch      <= '0;
      y_valid   <= 1'b0;
      scan_wrap <= 1'b0;
      ptr       <= '0;
      gap_cnt   <= '0;
      last_ch   <= '0;
      have_last <= 1'b0;
    end else begin
      scan_wrap <= 1'b0;
      if (do_load) begin
        y       <= din[int'(load_ch)*WIDTH +: WIDTH];
        y_ch    <= load_ch;
        y_valid <= 1'b1;
        state   <= ST_HOLD;
        // Only scan loads advance the pointer and feed wrap detection.
        if (mode) begin
          ptr       <= (int'(load_ch) == NUM_CH - 1) ? '0 : load_ch + 1'b1;
          scan_wrap <= have_last && (load_ch <= last_ch);
          last_ch   <= load_ch;
          have_last <= 1'b1;
        end
      end else begin
        unique case (state)
          ST_HOLD: begin
            if (accept) begin
              y_valid <= 1'b0;
              if (gap_mode) begin
                state   <= ST_GAP;
                gap_cnt <= GAP_LD;
              end else begin
                state <= ST_IDLE;
              end
            end
          end
          ST_GAP: begin
            if (gap_cnt == 8'd0) state <= ST_IDLE;
            else gap_cnt <= gap_cnt - 8'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mux_nto1_scan.sv
// Scoreboard bench: expected samples are queued by the stimulus and popped by
// per-instance monitors whenever a new sample appears on the output.
module tb_mux_nto1_scan;

  typedef struct packed {
    logic [7:0] y;
    logic [2:0] ch;
    logic       wrap;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // main instance: NUM_CH=8, GAP=0
  logic [63:0] din_m;
  logic [2:0]  sel_m;
  logic        mode_m, ready_m, valid_m, wrap_m;
  logic [7:0]  en_m, y_m;
  logic [2:0]  ych_m;

  // gap instance: NUM_CH=8, GAP=3
  logic [2:0]  sel_g;
  logic        mode_g, ready_g, valid_g, wrap_g;
  logic [7:0]  en_g, y_g;
  logic [2:0]  ych_g;

  // six-channel instance, so an out-of-range sel is representable
  logic [47:0] din_s;
  logic [2:0]  sel_s;
  logic        mode_s, ready_s, valid_s, wrap_s;
  logic [5:0]  en_s;
  logic [7:0]  y_s;
  logic [2:0]  ych_s;

  exp_t qm[$];
  exp_t qg[$];

  mux_nto1_scan #(.WIDTH(8), .NUM_CH(8), .GAP(0)) u_main (
    .clk(clk), .rst(rst), .din(din_m), .sel(sel_m), .mode(mode_m), .ch_en(en_m),
    .y(y_m), .y_ch(ych_m), .y_valid(valid_m), .y_ready(ready_m), .scan_wrap(wrap_m));

  mux_nto1_scan #(.WIDTH(8), .NUM_CH(8), .GAP(3)) u_gap (
    .clk(clk), .rst(rst), .din(din_m), .sel(sel_g), .mode(mode_g), .ch_en(en_g),
    .y(y_g), .y_ch(ych_g), .y_valid(valid_g), .y_ready(ready_g), .scan_wrap(wrap_g));

  mux_nto1_scan #(.WIDTH(8), .NUM_CH(6), .GAP(0)) u_six (
    .clk(clk), .rst(rst), .din(din_s), .sel(sel_s), .mode(mode_s), .ch_en(en_s),
    .y(y_s), .y_ch(ych_s), .y_valid(valid_s), .y_ready(ready_s), .scan_wrap(wrap_s));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int ch, input bit w);
    exp_t e;
    e.y    = 8'(8'h10 + ch);
    e.ch   = 3'(ch);
    e.wrap = w;
    return e;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // monitor for the main instance
  exp_t cur_m;
  logic pv_m = 1'b0, pa_m = 1'b0;
  always @(negedge clk) begin
    if (valid_m === 1'b1) begin
      if (!pv_m || pa_m) begin
        if (qm.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL main_unexpected: got sample ch %0d, expected none", ych_m);
          cur_m = '{y: y_m, ch: ych_m, wrap: wrap_m};
        end else begin
          cur_m = qm.pop_front();
          chk("main_wrap", 32'(wrap_m), 32'(cur_m.wrap));
        end
      end else begin
        chk("main_wrap_hold", 32'(wrap_m), 32'd0);
      end
      chk("main_y", 32'(y_m), 32'(cur_m.y));
      chk("main_ych", 32'(ych_m), 32'(cur_m.ch));
    end
    pv_m = (valid_m === 1'b1);
    pa_m = (valid_m === 1'b1) && (ready_m === 1'b1);
  end

  // monitor for the gap instance
  exp_t cur_g;
  logic pv_g = 1'b0, pa_g = 1'b0;
  always @(negedge clk) begin
    if (valid_g === 1'b1) begin
      if (!pv_g || pa_g) begin
        if (qg.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL gap_unexpected: got sample ch %0d, expected none", ych_g);
          cur_g = '{y: y_g, ch: ych_g, wrap: wrap_g};
        end else begin
          cur_g = qg.pop_front();
          chk("gap_wrap", 32'(wrap_g), 32'(cur_g.wrap));
        end
      end
      chk("gap_y", 32'(y_g), 32'(cur_g.y));
      chk("gap_ych", 32'(ych_g), 32'(cur_g.ch));
    end
    pv_g = (valid_g === 1'b1);
    pa_g = (valid_g === 1'b1) && (ready_g === 1'b1);
  end

  initial begin
    for (int k = 0; k < 8; k++) din_m[k*8 +: 8] = 8'(8'h10 + k);
    for (int k = 0; k < 6; k++) din_s[k*8 +: 8] = 8'(8'h10 + k);
    sel_m = 3'd0; mode_m = 1'b0; en_m = 8'h00; ready_m = 1'b0;
    sel_g = 3'd0; mode_g = 1'b1; en_g = 8'h00; ready_g = 1'b0;
    sel_s = 3'd7; mode_s = 1'b0; en_s = 6'h00; ready_s = 1'b0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;

    // manual sweep of sel 0..7, then sel=0 held under backpressure
    for (int k = 0; k < 8; k++) qm.push_back(mk(k, 1'b0));
    qm.push_back(mk(0, 1'b0));
    ready_m = 1'b1;
    for (int k = 0; k < 8; k++) begin
      sel_m = 3'(k);
      tick(1);
    end
    sel_m = 3'd0;
    tick(1);
    ready_m = 1'b0;
    tick(5);
    chk("man_hold_valid", 32'(valid_m), 32'd1);

    // reset mid-HOLD discards the pending sample
    rst = 1'b1; mode_m = 1'b1; en_m = 8'h00;
    tick(2);
    chk("rst_y", 32'(y_m), 32'd0);
    chk("rst_ych", 32'(ych_m), 32'd0);
    chk("rst_valid", 32'(valid_m), 32'd0);
    chk("rst_wrap", 32'(wrap_m), 32'd0);
    rst = 1'b0;

    // scan over ch_en=1010_0101
    begin
      int seq[10] = '{0, 2, 5, 7, 0, 2, 5, 7, 0, 2};
      for (int i = 0; i < 10; i++) qm.push_back(mk(seq[i], (i == 4 || i == 8)));
    end
    en_m = 8'hA5; ready_m = 1'b1;
    tick(10);
    // clear the mask while holding: pending sample still delivered
    ready_m = 1'b0; en_m = 8'h00;
    tick(2);
    chk("clr_pending", 32'(valid_m), 32'd1);
    ready_m = 1'b1;
    tick(1);
    for (int i = 0; i < 3; i++) begin
      chk("clr_idle", 32'(valid_m), 32'd0);
      tick(1);
    end
    // single enabled channel: every load after the first wraps
    qm.push_back(mk(6, 1'b0));
    for (int i = 0; i < 3; i++) qm.push_back(mk(6, 1'b1));
    en_m = 8'h40;
    tick(4);
    ready_m = 1'b0;

    // manual ch 3 held across a switch to scan mode
    rst = 1'b1; mode_m = 1'b0; sel_m = 3'd3; en_m = 8'hFF;
    tick(2);
    rst = 1'b0;
    qm.push_back(mk(3, 1'b0));
    for (int k = 0; k < 4; k++) qm.push_back(mk(k, 1'b0));
    tick(1);
    mode_m = 1'b1;
    tick(2);
    chk("toggle_hold_ch", 32'(ych_m), 32'd3);
    ready_m = 1'b1;
    tick(4);
    ready_m = 1'b0;
    rst = 1'b1; en_m = 8'h00;
    tick(2);
    rst = 1'b0;

    // GAP=3 scan: one valid cycle in four, backpressure on ch 3
    for (int k = 0; k < 6; k++) qg.push_back(mk(k, 1'b0));
    en_g = 8'hFF; ready_g = 1'b1;
    tick(1);
    for (int i = 0; i < 8; i++) begin
      chk("gap_pattern", 32'(valid_g), 32'((i % 4) == 0));
      tick(1);
    end
    tick(4);
    ready_g = 1'b0;
    tick(6);
    chk("gap_bp_y", 32'(y_g), 32'h13);
    ready_g = 1'b1;
    tick(1);
    chk("gap_after_bp", 32'(valid_g), 32'd0);
    tick(3);
    chk("gap_next_valid", 32'(valid_g), 32'd1);
    tick(4);
    ready_g = 1'b0;

    // six channels: sel 6 and 7 are out of range, sel 5 loads
    for (int s = 6; s < 8; s++) begin
      sel_s = 3'(s);
      tick(2);
      chk("six_noload", 32'(valid_s), 32'd0);
    end
    sel_s = 3'd5;
    tick(1);
    chk("six_valid", 32'(valid_s), 32'd1);
    chk("six_y", 32'(y_s), 32'h15);
    chk("six_ych", 32'(ych_s), 32'd5);

    tick(2);
    chk("main_queue_drained", 32'(qm.size()), 32'd0);
    chk("gap_queue_drained", 32'(qg.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
